// File: rtl/electronic_voting_machine_if.sv
// Ballot and result bundle between the button front-end, the tallier and the display.
interface electronic_voting_machine_if #(parameter int CNT_W = 8);
  logic             c1;
  logic             c2;
  logic             c3;
  logic             endVoting;
  logic [CNT_W-1:0] count_c1;
  logic [CNT_W-1:0] count_c2;
  logic [CNT_W-1:0] count_c3;
  logic [1:0]       winner;
  logic             c1_tie_c2;
  logic             c2_tie_c3;
  logic             c1_tie_c3;

  modport master (
    output c1, c2, c3, endVoting,
    input  count_c1, count_c2, count_c3, winner, c1_tie_c2, c2_tie_c3, c1_tie_c3
  );

  modport slave (
    input  c1, c2, c3, endVoting,
    output count_c1, count_c2, count_c3, winner, c1_tie_c2, c2_tie_c3, c1_tie_c3
  );
endinterface

// File: rtl/electronic_voting_machine.sv
// Three-candidate saturating vote tallier with end-of-poll winner and tie flags.
// Optional pairwise tie flags are built only when EVM_TIE_FLAGS_EN is defined.
module electronic_voting_machine #(
  parameter int CNT_W = 8
) (
  input logic                        clk,
  input logic                        rst,
  electronic_voting_machine_if.slave bus
);

  typedef enum logic {OPEN, CLOSED} poll_e;

  poll_e            state_q, state_d;
  logic [2:0]       prev_q;
  logic [2:0]       lvl;
  logic [2:0]       rise;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic [1:0]       win;

  assign lvl  = {bus.c3, bus.c2, bus.c1};
  assign rise = lvl & ~prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= OPEN;
      prev_q  <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= lvl;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // A ballot with more than one rising button is discarded entirely.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == OPEN) begin
      if (bus.endVoting) state_d = CLOSED;
      if ($onehot(rise)) begin
        for (int i = 0; i < 3; i++) begin
          if (rise[i] && (cnt_q[i] != {CNT_W{1'b1}})) cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    win = 2'd0;
    if (state_q == CLOSED) begin
      if ((cnt_q[0] > cnt_q[1]) && (cnt_q[0] > cnt_q[2]))      win = 2'd1;
      else if ((cnt_q[1] > cnt_q[0]) && (cnt_q[1] > cnt_q[2])) win = 2'd2;
      else if ((cnt_q[2] > cnt_q[0]) && (cnt_q[2] > cnt_q[1])) win = 2'd3;
    end
  end

  assign bus.count_c1 = cnt_q[0];
  assign bus.count_c2 = cnt_q[1];
  assign bus.count_c3 = cnt_q[2];
  assign bus.winner   = win;

`ifdef EVM_TIE_FLAGS_EN
  logic [CNT_W-1:0] max_cnt;

  always_comb begin
    max_cnt = cnt_q[0];
    if (cnt_q[1] > max_cnt) max_cnt = cnt_q[1];
    if (cnt_q[2] > max_cnt) max_cnt = cnt_q[2];
  end

  // Equal pair tied for first; zero is excluded so an empty poll shows no tie.
  assign bus.c1_tie_c2 = (state_q == CLOSED) && (cnt_q[0] == cnt_q[1]) &&
                         (cnt_q[0] == max_cnt) && (cnt_q[0] != '0);
  assign bus.c2_tie_c3 = (state_q == CLOSED) && (cnt_q[1] == cnt_q[2]) &&
                         (cnt_q[1] == max_cnt) && (cnt_q[1] != '0);
  assign bus.c1_tie_c3 = (state_q == CLOSED) && (cnt_q[0] == cnt_q[2]) &&
                         (cnt_q[0] == max_cnt) && (cnt_q[0] != '0);
`else
  assign bus.c1_tie_c2 = 1'b0;
  assign bus.c2_tie_c3 = 1'b0;
  assign bus.c1_tie_c3 = 1'b0;
`endif

endmodule

// File: tb/tb_electronic_voting_machine.sv
// Directed bench for electronic_voting_machine; tie expectations follow EVM_TIE_FLAGS_EN.
module tb_electronic_voting_machine;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  electronic_voting_machine_if #(.CNT_W(8)) bus ();

  electronic_voting_machine #(.CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int tie(input int t);
`ifdef EVM_TIE_FLAGS_EN
    return t;
`else
    return 0;
`endif
  endfunction

  task automatic check_all(input string tag, input int e1, input int e2, input int e3,
                           input int ew, input int t12, input int t23, input int t13);
    check({tag, ".c1"},  int'(bus.count_c1), e1);
    check({tag, ".c2"},  int'(bus.count_c2), e2);
    check({tag, ".c3"},  int'(bus.count_c3), e3);
    check({tag, ".win"}, int'(bus.winner), ew);
    check({tag, ".t12"}, int'(bus.c1_tie_c2), tie(t12));
    check({tag, ".t23"}, int'(bus.c2_tie_c3), tie(t23));
    check({tag, ".t13"}, int'(bus.c1_tie_c3), tie(t13));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_c(input int k, input logic v);
    case (k)
      1: bus.c1 = v;
      2: bus.c2 = v;
      default: bus.c3 = v;
    endcase
  endtask

  task automatic vote(input int k);
    set_c(k, 1'b1);
    step();
    set_c(k, 1'b0);
    step();
  endtask

  task automatic close_poll();
    bus.endVoting = 1'b1;
    step();
    bus.endVoting = 1'b0;
  endtask

  // Reset is pulsed between clock edges and checked before any edge occurs.
  task automatic do_reset(input string tag);
    #2;
    rst = 1'b0;
    bus.c1 = 1'b0; bus.c2 = 1'b0; bus.c3 = 1'b0; bus.endVoting = 1'b0;
    #1;
    check_all(tag, 0, 0, 0, 0, 0, 0, 0);
    #1;
    rst = 1'b1;
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus.c1 = 1'b0; bus.c2 = 1'b0; bus.c3 = 1'b0; bus.endVoting = 1'b0;
    #2;
    check_all("por", 0, 0, 0, 0, 0, 0, 0);
    #5;
    rst = 1'b1;
    step();

    // Sequence C1,C2,C3,C3,C1,C1,C3,C1
    vote(1); vote(2); vote(3); vote(3); vote(1); vote(1); vote(3); vote(1);
    check_all("seq_open", 4, 1, 3, 0, 0, 0, 0);
    close_poll();
    check_all("seq_closed", 4, 1, 3, 1, 0, 0, 0);

    // Votes after close ignored, endVoting drop has no effect
    vote(3); vote(3); vote(3);
    bus.endVoting = 1'b0;
    step();
    check_all("after_close", 4, 1, 3, 1, 0, 0, 0);

    do_reset("rst_a");
    vote(2); vote(3); vote(2); vote(3);
    close_poll();
    check_all("tie23", 0, 2, 2, 0, 0, 1, 0);

    do_reset("rst_b");
    bus.c1 = 1'b1;
    repeat (5) step();
    check("hold_c1", int'(bus.count_c1), 1);
    bus.c1 = 1'b0;
    step();
    bus.c1 = 1'b1; bus.c2 = 1'b1;
    step();
    bus.c1 = 1'b0; bus.c2 = 1'b0;
    step();
    check_all("double_rise", 1, 0, 0, 0, 0, 0, 0);
    // Vote in the same cycle as close is still counted
    bus.c2 = 1'b1; bus.endVoting = 1'b1;
    step();
    bus.c2 = 1'b0; bus.endVoting = 1'b0;
    check_all("same_cycle", 1, 1, 0, 0, 1, 0, 0);
    vote(3);
    check_all("same_cycle_post", 1, 1, 0, 0, 1, 0, 0);

    do_reset("rst_c");
    vote(1); vote(2); vote(3);
    close_poll();
    check_all("tie3", 1, 1, 1, 0, 1, 1, 1);

    do_reset("rst_d");
    close_poll();
    check_all("empty", 0, 0, 0, 0, 0, 0, 0);

    do_reset("rst_e");
    repeat (300) vote(1);
    check_all("sat_open", 255, 0, 0, 0, 0, 0, 0);
    close_poll();
    check_all("sat_closed", 255, 0, 0, 1, 0, 0, 0);
    do_reset("rst_async");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
